// File: rtl/i2c_sync_fifo.sv
// ----------------------------------------------------------------------------
// i2c_sync_fifo
// Single-clock FIFO used on the I2C master TX/RX data paths, between the
// APB/register side and the I2C byte engine.
//
// Optional feature macro: FIFO_STICKY_ERR_EN
//   undefined : overflow_o / underflow_o are one-cycle pulses, no clear_err_i
//   defined   : overflow_o / underflow_o hold until clear_err_i is sampled
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        asynchronous active-high reset
//   flush_i        synchronous clear of pointers and count
//   write_en_i     write request, data_i is the word to store
//   read_en_i      read request
//   data_o         registered read data (holds when no read is accepted)
//   data_valid_o   data_o was loaded by an accepted read this cycle
//   count_o        stored words, 0..depth
//   full_o         count_o == depth
//   empty_o        count_o == 0
//   almost_full_o  count_o >= almost_full_level
//   almost_empty_o count_o <= almost_empty_level
//   overflow_o     write rejected because the FIFO was full
//   underflow_o    read rejected because the FIFO was empty
//   clear_err_i    (FIFO_STICKY_ERR_EN only) clears the sticky error flags
// ----------------------------------------------------------------------------
module i2c_sync_fifo #(
    parameter int data_size          = 8,
    parameter int addr_size          = 4,
    parameter int almost_full_level  = 14,
    parameter int almost_empty_level = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 write_en_i,
    input  logic [data_size-1:0] data_i,
    input  logic                 read_en_i,
    output logic [data_size-1:0] data_o,
    output logic                 data_valid_o,
    output logic [addr_size:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic                 overflow_o,
    output logic                 underflow_o
`ifdef FIFO_STICKY_ERR_EN
    ,
    input  logic                 clear_err_i
`endif
);

    localparam int unsigned DEPTH_I = 1 << addr_size;
    localparam int unsigned AF_I    = almost_full_level;
    localparam int unsigned AE_I    = almost_empty_level;

    localparam logic [addr_size:0] DEPTH  = DEPTH_I[addr_size:0];
    localparam logic [addr_size:0] AF_LVL = AF_I[addr_size:0];
    localparam logic [addr_size:0] AE_LVL = AE_I[addr_size:0];
    localparam logic [addr_size:0] ONE    = {{addr_size{1'b0}}, 1'b1};

    logic [data_size-1:0] r_mem [0:DEPTH_I-1];

    logic [addr_size:0]   r_wr_ptr;
    logic [addr_size:0]   r_rd_ptr;
    logic [addr_size:0]   r_count;
    logic [data_size-1:0] r_data;
    logic                 r_valid;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_afull;
    logic                 r_aempty;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_ovf_evt;
    logic                 w_unf_evt;
    logic [addr_size:0]   w_count_nxt;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write paired with an accepted read. No bypass when empty.
    assign w_rd_acc  = read_en_i & ~r_empty & ~flush_i;
    assign w_wr_acc  = write_en_i & (~r_full | w_rd_acc) & ~flush_i;
    assign w_ovf_evt = write_en_i & r_full & ~w_rd_acc & ~flush_i;
    assign w_unf_evt = read_en_i & r_empty & ~flush_i;

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + ONE;
                2'b01:   w_count_nxt = r_count - ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage is not reset; contents are discarded logically via the pointers.
    always_ff @(posedge clock_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[addr_size-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ONE;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ONE;
            end
            if (w_rd_acc) r_data <= r_mem[r_rd_ptr[addr_size-1:0]];
            r_valid  <= w_rd_acc;
            r_count  <= w_count_nxt;
            // Flags follow the next count so they move together with count_o.
            r_full   <= (w_count_nxt == DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= AF_LVL);
            r_aempty <= (w_count_nxt <= AE_LVL);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            // A new error in the clearing cycle keeps the flag set.
            r_ovf <= w_ovf_evt | (r_ovf & ~clear_err_i);
            r_unf <= w_unf_evt | (r_unf & ~clear_err_i);
`else
            r_ovf <= w_ovf_evt;
            r_unf <= w_unf_evt;
`endif
        end
    end

    assign data_o         = r_data;
    assign data_valid_o   = r_valid;
    assign count_o        = r_count;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_afull;
    assign almost_empty_o = r_aempty;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;

endmodule

// File: tb/tb_i2c_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_i2c_sync_fifo
// Directed self-checking bench for i2c_sync_fifo with default parameters
// (8-bit data, depth 16, almost_full 14, almost_empty 2).
// Build with FIFO_STICKY_ERR_EN defined to exercise the sticky error flags.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_sync_fifo;

`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       write_en_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       read_en_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic [4:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic       overflow_o;
    logic       underflow_o;
`ifdef FIFO_STICKY_ERR_EN
    logic       clear_err_i = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    i2c_sync_fifo #(
        .data_size(8),
        .addr_size(4),
        .almost_full_level(14),
        .almost_empty_level(2)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .write_en_i(write_en_i),
        .data_i(data_i),
        .read_en_i(read_en_i),
        .data_o(data_o),
        .data_valid_o(data_valid_o),
        .count_o(count_o),
        .full_o(full_o),
        .empty_o(empty_o),
        .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o),
        .overflow_o(overflow_o),
        .underflow_o(underflow_o)
`ifdef FIFO_STICKY_ERR_EN
        ,
        .clear_err_i(clear_err_i)
`endif
    );

    always #5 clock_i = ~clock_i;

    // Advance past one rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_inputs();
        write_en_i = 1'b0;
        read_en_i  = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic clear_errors();
`ifdef FIFO_STICKY_ERR_EN
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;
`endif
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        #2;
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
        n_cmp++; if (almost_empty_o !== 1'b1) begin n_err++; $display("FAIL reset_aempty got=%b exp=1", almost_empty_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full_o); end
        n_cmp++; if (almost_full_o !== 1'b0) begin n_err++; $display("FAIL reset_afull got=%b exp=0", almost_full_o); end
        n_cmp++; if (count_o !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", data_valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data_o); end
        n_cmp++; if ({overflow_o, underflow_o} !== 2'b00) begin n_err++; $display("FAIL reset_err got=%b exp=00", {overflow_o, underflow_o}); end
        step();
        reset_i = 1'b0;
        step();
        // Idle after reset: nothing should change.
        n_cmp++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL idle_state got count=%0d empty=%b exp count=0 empty=1", count_o, empty_o); end

        // Asynchronous reset between clock edges discards stored words immediately.
        write_en_i = 1'b1; data_i = 8'h77;
        step(); step();
        write_en_i = 1'b0;
        n_cmp++; if (count_o !== 5'd2) begin n_err++; $display("FAIL pre_async_count got=%0d exp=2", count_o); end
        #2 reset_i = 1'b1;
        #1;
        n_cmp++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL async_reset got count=%0d empty=%b exp count=0 empty=1", count_o, empty_o); end
        step();
        reset_i = 1'b0;
        step();
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            write_en_i = 1'b1;
            data_i     = 8'(i + 1);
            step();
        end
        write_en_i = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            write_en_i = 1'b1;
            data_i     = 8'(i + 1);
            step();
            n_cmp++; if (count_o !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, i + 1); end
            n_cmp++; if ({full_o, almost_full_o, almost_empty_o, empty_o} !== {(i == 15), (i >= 13), (i <= 1), 1'b0})
                begin n_err++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {full_o, almost_full_o, almost_empty_o, empty_o}, {(i == 15), (i >= 13), (i <= 1), 1'b0}); end
        end
        write_en_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_en_i = 1'b1;
            step();
            n_cmp++; if (data_valid_o !== 1'b1 || data_o !== 8'(i + 1))
                begin n_err++; $display("FAIL drain_data[%0d] got valid=%b data=%h exp valid=1 data=%h", i, data_valid_o, data_o, 8'(i + 1)); end
            n_cmp++; if (count_o !== 5'(15 - i) || empty_o !== (i == 15))
                begin n_err++; $display("FAIL drain_count[%0d] got count=%0d empty=%b exp count=%0d empty=%b", i, count_o, empty_o, 15 - i, (i == 15)); end
        end
        read_en_i = 1'b0;
        step();
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_valid_drop got=%b exp=0", data_valid_o); end
    endtask

    task automatic test_full_rw_and_errors();
        logic [7:0] exp_d;
        fill16();
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_before_rw got=%b exp=1", full_o); end
        write_en_i = 1'b1; read_en_i = 1'b1; data_i = 8'hAA;
        step();
        idle_inputs();
        n_cmp++; if (count_o !== 5'd16 || full_o !== 1'b1) begin n_err++; $display("FAIL full_rw_count got count=%0d full=%b exp count=16 full=1", count_o, full_o); end
        n_cmp++; if (data_o !== 8'h01 || data_valid_o !== 1'b1) begin n_err++; $display("FAIL full_rw_data got data=%h valid=%b exp data=01 valid=1", data_o, data_valid_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL full_rw_ovf got=%b exp=0", overflow_o); end

        write_en_i = 1'b1; data_i = 8'h55;
        step();
        write_en_i = 1'b0;
        n_cmp++; if (overflow_o !== 1'b1 || count_o !== 5'd16) begin n_err++; $display("FAIL overflow_pulse got ovf=%b count=%0d exp ovf=1 count=16", overflow_o, count_o); end
        step();
        n_cmp++; if (overflow_o !== STICKY) begin n_err++; $display("FAIL overflow_after got=%b exp=%b", overflow_o, STICKY); end
        clear_errors();

        // Contents are now 0x02..0x10 followed by 0xAA; 0x55 was dropped.
        for (int i = 0; i < 16; i++) begin
            exp_d = (i == 15) ? 8'hAA : 8'(i + 2);
            read_en_i = 1'b1;
            step();
            n_cmp++; if (data_o !== exp_d || data_valid_o !== 1'b1) begin n_err++; $display("FAIL order_after_rw[%0d] got=%h exp=%h", i, data_o, exp_d); end
        end
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL empty_after_drain got=%b exp=1", empty_o); end

        // Read while empty: rejected, data_o keeps 0xAA.
        step();
        read_en_i = 1'b0;
        n_cmp++; if (underflow_o !== 1'b1 || data_valid_o !== 1'b0 || data_o !== 8'hAA)
            begin n_err++; $display("FAIL underflow_pulse got unf=%b valid=%b data=%h exp unf=1 valid=0 data=aa", underflow_o, data_valid_o, data_o); end
        step();
        n_cmp++; if (underflow_o !== STICKY) begin n_err++; $display("FAIL underflow_after got=%b exp=%b", underflow_o, STICKY); end
        clear_errors();
    endtask

    task automatic test_flush_and_wrap();
        for (int i = 0; i < 5; i++) begin
            write_en_i = 1'b1; data_i = 8'(8'h21 + i);
            step();
        end
        n_cmp++; if (count_o !== 5'd5) begin n_err++; $display("FAIL pre_flush_count got=%0d exp=5", count_o); end
        flush_i = 1'b1; write_en_i = 1'b1; read_en_i = 1'b1; data_i = 8'hEE;
        step();
        idle_inputs();
        n_cmp++; if (count_o !== 5'd0 || empty_o !== 1'b1 || data_valid_o !== 1'b0)
            begin n_err++; $display("FAIL flush_state got count=%0d empty=%b valid=%b exp count=0 empty=1 valid=0", count_o, empty_o, data_valid_o); end
        n_cmp++; if ({overflow_o, underflow_o} !== 2'b00 || data_o !== 8'hAA)
            begin n_err++; $display("FAIL flush_errs_hold got err=%b data=%h exp err=00 data=aa", {overflow_o, underflow_o}, data_o); end

        // Prime one word then run 40 simultaneous write/read pairs; pointers wrap.
        write_en_i = 1'b1; data_i = 8'h80;
        step();
        for (int i = 1; i <= 40; i++) begin
            write_en_i = 1'b1; read_en_i = 1'b1; data_i = 8'(8'h80 + i);
            step();
            n_cmp++; if (data_o !== 8'(8'h80 + i - 1) || data_valid_o !== 1'b1 || count_o !== 5'd1)
                begin n_err++; $display("FAIL wrap[%0d] got data=%h valid=%b count=%0d exp data=%h valid=1 count=1", i, data_o, data_valid_o, count_o, 8'(8'h80 + i - 1)); end
        end
        idle_inputs();
        read_en_i = 1'b1;
        step();
        read_en_i = 1'b0;
        n_cmp++; if (data_o !== 8'hA8 || empty_o !== 1'b1) begin n_err++; $display("FAIL wrap_last got data=%h empty=%b exp data=a8 empty=1", data_o, empty_o); end
        step();
    endtask

`ifdef FIFO_STICKY_ERR_EN
    task automatic test_sticky();
        read_en_i = 1'b1;
        step();
        read_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL sticky_hold[%0d] got=%b exp=1", i, underflow_o); end
            step();
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL sticky_flush got=%b exp=1", underflow_o); end
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;
        n_cmp++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL sticky_clear got=%b exp=0", underflow_o); end
        clear_err_i = 1'b1; read_en_i = 1'b1;
        step();
        clear_err_i = 1'b0; read_en_i = 1'b0;
        n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL sticky_clear_vs_new got=%b exp=1", underflow_o); end
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw_and_errors();
        test_flush_and_wrap();
`ifdef FIFO_STICKY_ERR_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_sync_fifo.md
Name: i2c_sync_fifo

Overview:
- Single-clock, parametrised FIFO (storage plus control) for the I2C master TX/RX data paths.
- Generalises the existing bare memory array with:
  - write/read pointer management
  - fill count
  - full/empty and programmable almost-full/almost-empty flags
  - registered read data with a valid strobe
  - synchronous flush
  - overflow/underflow reporting
- Sits between the APB/register side and the I2C byte engine when both share one clock.

Parameters:
- data_size, 8: width of each stored word in bits.
- addr_size, 4: address width; depth = 2^addr_size words (16).
- almost_full_level, 14: almost_full_o asserts when count >= this value; legal range 1..depth.
- almost_empty_level, 2: almost_empty_o asserts when count <= this value; legal range 0..depth-1.

Ports:
- clock_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous clear of pointers and count.
- write_en_i  input  1  write request.
- data_i  input  data_size  write data.
- read_en_i  input  1  read request.
- data_o  output  data_size  registered read data.
- data_valid_o  output  1  data_o updated this cycle by an accepted read.
- count_o  output  addr_size+1  number of stored words, 0..depth.
- full_o  output  1  count_o == depth.
- empty_o  output  1  count_o == 0.
- almost_full_o  output  1  count_o >= almost_full_level.
- almost_empty_o  output  1  count_o <= almost_empty_level.
- overflow_o  output  1  write rejected.
- underflow_o  output  1  read rejected.
- clear_err_i  input  1  present only with FIFO_STICKY_ERR_EN; clears sticky error flags.

Behaviour:
- Reset (async, immediate, regardless of clock):
  - pointers, count_o, data_o, data_valid_o, full_o, almost_full_o, overflow_o, underflow_o = 0.
  - empty_o = 1; almost_empty_o = 1 (0 <= almost_empty_level).
  - Reset mid-operation discards all contents logically; memory array is not cleared.
- Pointers:
  - addr_size+1 bits wide; the MSB distinguishes full from empty.
  - Each pointer increments by 1 per accepted operation and wraps naturally mod 2^(addr_size+1).
  - Memory is indexed by pointer[addr_size-1:0].
- Write accepted = write_en_i & (~full_o | read accepted) & ~flush_i.
  - When full, a simultaneous accepted read allows the write.
  - Memory returns the old word before the overwrite (nonblocking semantics).
- Read accepted = read_en_i & ~empty_o & ~flush_i.
  - When empty, a simultaneous write is accepted but the read is rejected; there is no write-to-read bypass.
- Read latency 1:
  - On an accepted read, data_o <= mem[rd_ptr] and data_valid_o = 1 in the next cycle.
  - Otherwise data_valid_o = 0 and data_o holds its value.
- Count update per cycle:
  - write only: +1
  - read only: -1
  - both or neither: unchanged
- All flags are registered and derived from the next count, so they change in the same cycle as count_o. They are never combinational from the request inputs.
- flush_i has priority over write and read:
  - next cycle: pointers = 0, count_o = 0, empty_o = 1, data_valid_o = 0.
  - data_o holds its value.
  - overflow/underflow are not raised for requests presented during flush.
- overflow_o: one-cycle pulse, the cycle after write_en_i while full with no accepted read.
- underflow_o: one-cycle pulse, the cycle after read_en_i while empty.
- No state machine beyond the pointer/count registers. Target implementation is ~150-250 lines.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined:
  - overflow_o and underflow_o are sticky; once set they remain 1 until clear_err_i = 1 is sampled. The flag is 0 the next cycle.
  - A new error in the same cycle as clear_err_i wins: the flag stays 1.
  - flush_i does not clear the error flags; reset does.
  - clear_err_i port exists.
- Undefined:
  - Single-cycle pulse behaviour as above.
  - clear_err_i port is absent.

Test Plan (defaults: data_size 8, addr_size 4, depth 16):
- Reset then idle -> empty_o = 1, almost_empty_o = 1, full_o = 0, count_o = 0, data_valid_o = 0, data_o = 0x00.
- Write 0x01..0x10 on 16 consecutive cycles, then read 16 -> full_o = 1 after the 16th write; almost_full_o = 1 from count 14. Reads return 0x01..0x10 in order, each one cycle after read_en_i, with data_valid_o high. empty_o = 1 at the end.
- Fill to 16, then assert write_en_i and read_en_i together with data_i = 0xAA -> count_o stays 16; the read returns the oldest word (0x01); 0xAA is stored; overflow_o = 0.
- When full, write 0x55 alone -> overflow_o pulses for 1 cycle, count_o stays 16. When empty, read alone -> underflow_o pulses, data_valid_o = 0, data_o unchanged.
- Write 5 words, assert flush_i together with write_en_i and read_en_i -> next cycle count_o = 0, empty_o = 1, data_valid_o = 0, no error pulses. Then 40 write/read pairs verify pointer wrap-around with correct data ordering.
- With FIFO_STICKY_ERR_EN: cause underflow -> underflow_o stays 1 for 10 cycles; clear_err_i for 1 cycle -> 0 the next cycle. Clear and underflow in the same cycle -> stays 1.
